// File: rtl/alu_pkg.sv
// Shared definitions for the bit-serial ALU sequencer: op encodings and FSM states.
package alu_pkg;

    localparam logic [1:0] ALU_OP_AND  = 2'd0;
    localparam logic [1:0] ALU_OP_OR   = 2'd1;
    localparam logic [1:0] ALU_OP_ADD  = 2'd2;
    localparam logic [1:0] ALU_OP_LESS = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

endpackage

// File: rtl/alu_serial_slice.sv
// Combinational 1-bit ALU slice: optional operand inversion, full adder,
// and AND/OR/ADD/LESS result select. The set output is the raw adder sum.
module alu_serial_slice
    import alu_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       a_invert,
    input  logic       b_invert,
    input  logic       ci,
    input  logic [1:0] op,
    input  logic       less,
    output logic       result,
    output logic       co,
    output logic       set
);

    logic ainv;
    logic binv;
    logic sum;

    // Slice datapath: invert, add, and select the per-op result bit
    always_comb begin
        ainv = a ^ a_invert;
        binv = b ^ b_invert;
        sum  = ainv ^ binv ^ ci;
        co   = (ainv & binv) | (ci & (ainv ^ binv));
        set  = sum;
        case (op)
            ALU_OP_AND: result = ainv & binv;
            ALU_OP_OR:  result = ainv | binv;
            ALU_OP_ADD: result = sum;
            default:    result = less;
        endcase
    end

endmodule

// File: rtl/alu_serial_seq.sv
// Bit-serial ALU sequencer: one slice per clock, LSB first, registered carry.
// Optional macro ALU_SLT_OVF_FIX_EN: for LESS, result[0] = set ^ overflow
// (overflow-corrected signed compare); otherwise result[0] = raw set.
module alu_serial_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             a_invert,
    input  logic             b_invert,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             co,
    output logic             overflow
);

    state_t           state;
    state_t           state_nxt;

    logic [CW-1:0]    cnt;
    logic             carry;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] rsr;
    logic             ai_q;
    logic             bi_q;
    logic [1:0]       op_q;
    logic             set_q;
    logic             co_q;
    logic             ovf_q;

    logic             load;
    logic             step;
    logic             last;
    logic             finish;
    logic [WIDTH-1:0] fin_result;

    logic             sl_result;
    logic             sl_co;
    logic             sl_set;

    alu_serial_slice u_slice (
        .a        (sa[0]),
        .b        (sb[0]),
        .a_invert (ai_q),
        .b_invert (bi_q),
        .ci       (carry),
        .op       (op_q),
        .less     (1'b0),
        .result   (sl_result),
        .co       (sl_co),
        .set      (sl_set)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_RUN;
            ST_RUN:  if (last)  state_nxt = ST_FIN;
            ST_FIN:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Control strobes and the final result word assembled in FIN
    always_comb begin
        load       = (state == ST_IDLE) && start;
        step       = (state == ST_RUN);
        last       = step && (cnt == CW'(WIDTH - 1));
        finish     = (state == ST_FIN);
        fin_result = rsr;
        if (op_q == ALU_OP_LESS) begin
            fin_result = '0;
`ifdef ALU_SLT_OVF_FIX_EN
            fin_result[0] = set_q ^ ovf_q;
`else
            fin_result[0] = set_q;
`endif
        end
    end

    // Datapath: operand/result shift registers, carry, counter, output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            carry    <= 1'b0;
            sa       <= '0;
            sb       <= '0;
            rsr      <= '0;
            ai_q     <= 1'b0;
            bi_q     <= 1'b0;
            op_q     <= ALU_OP_AND;
            set_q    <= 1'b0;
            co_q     <= 1'b0;
            ovf_q    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            zero     <= 1'b0;
            co       <= 1'b0;
            overflow <= 1'b0;
        end else begin
            // busy/done lag the state by one edge so done lands with the result
            busy <= (state != ST_IDLE);
            done <= finish;
            if (load) begin
                sa    <= a;
                sb    <= b;
                ai_q  <= a_invert;
                bi_q  <= b_invert;
                op_q  <= op;
                carry <= b_invert;
                cnt   <= '0;
            end
            if (step) begin
                sa    <= sa >> 1;
                sb    <= sb >> 1;
                rsr   <= {sl_result, rsr[WIDTH-1:1]};
                carry <= sl_co;
                if (last) begin
                    set_q <= sl_set;
                    co_q  <= sl_co;
                    ovf_q <= carry ^ sl_co;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
            if (finish) begin
                cnt      <= '0;
                result   <= fin_result;
                zero     <= (fin_result == '0);
                co       <= co_q;
                overflow <= ovf_q;
            end
        end
    end

endmodule

// File: tb/tb_alu_serial_seq.sv
// Self-checking bench for alu_serial_seq (WIDTH=8) with a scoreboard queue.
module tb_alu_serial_seq;

    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] res;
        logic         z;
        logic         c;
        logic         v;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         a_invert;
    logic         b_invert;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         zero;
    logic         co;
    logic         overflow;

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    alu_serial_seq #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a_invert (a_invert),
        .b_invert (b_invert),
        .op       (op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .zero     (zero),
        .co       (co),
        .overflow (overflow)
    );

    // Word-level reference: whole-word adds instead of a bit loop
    function automatic exp_t model(input logic [W-1:0] xa, input logic [W-1:0] xb,
                                   input logic ai, input logic bi, input logic [1:0] xo);
        exp_t         e;
        logic [W-1:0] aa;
        logic [W-1:0] bb;
        logic [W:0]   s;
        logic [W-1:0] lo;
        logic         cin;
        aa  = ai ? ~xa : xa;
        bb  = bi ? ~xb : xb;
        s   = {1'b0, aa} + {1'b0, bb} + (W+1)'(bi);
        lo  = {1'b0, aa[W-2:0]} + {1'b0, bb[W-2:0]} + W'(bi);
        cin = lo[W-1];
        e.c = s[W];
        e.v = cin ^ s[W];
        case (xo)
            2'd0:    e.res = aa & bb;
            2'd1:    e.res = aa | bb;
            2'd2:    e.res = s[W-1:0];
            default: begin
                e.res = '0;
`ifdef ALU_SLT_OVF_FIX_EN
                e.res[0] = s[W-1] ^ e.v;
`else
                e.res[0] = s[W-1];
`endif
            end
        endcase
        e.z = (e.res == '0);
        return e;
    endfunction

    // Present a request for one edge and record its expected outcome
    task automatic issue(input logic [W-1:0] xa, input logic [W-1:0] xb,
                         input logic ai, input logic bi, input logic [1:0] xo);
        a        = xa;
        b        = xb;
        a_invert = ai;
        b_invert = bi;
        op       = xo;
        start    = 1'b1;
        sb.push_back(model(xa, xb, ai, bi, xo));
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Wait (bounded) for done; optionally pulse start mid-RUN and in FIN
    task automatic wait_done(input bit poke, output int lat, output int busy_n);
        lat    = 0;
        busy_n = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (busy) busy_n++;
            if (done) begin
                lat   = k;
                start = 1'b0;
                break;
            end
            start = poke && (k == 3 || k == W);
            if (start) begin
                a        = W'($urandom);
                b        = W'($urandom);
                op       = 2'($urandom);
                a_invert = 1'($urandom);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        a = '0; b = '0; a_invert = 1'b0; b_invert = 1'b0; op = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({busy, done, result, zero, co, overflow} !== '0)
            begin bad++; $display("FAIL reset: got busy=%b done=%b res=%h z=%b c=%b v=%b want all 0",
                                  busy, done, result, zero, co, overflow); end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_add();
        int   lat, bn;
        exp_t e;
        issue(8'h0F, 8'h01, 1'b0, 1'b0, 2'd2);
        wait_done(1'b0, lat, bn);
        total++;
        if (lat !== W + 1) begin bad++; $display("FAIL add_latency: got %0d want %0d", lat, W + 1); end
        total++;
        if (bn !== W + 1) begin bad++; $display("FAIL add_busy_cycles: got %0d want %0d", bn, W + 1); end
        e = sb.pop_front();
        total++;
        if ({result, zero, co, overflow} !== {8'h10, 1'b0, 1'b0, 1'b0} || e.res !== 8'h10)
            begin bad++; $display("FAIL add: got res=%h z=%b c=%b v=%b want res=10 z=0 c=0 v=0",
                                  result, zero, co, overflow); end
    endtask

    task automatic test_sub();
        int   lat, bn;
        exp_t e;
        issue(8'h05, 8'h05, 1'b0, 1'b1, 2'd2);
        wait_done(1'b0, lat, bn);
        e = sb.pop_front();
        total++;
        if ({result, zero, co, overflow} !== {e.res, e.z, e.c, e.v})
            begin bad++; $display("FAIL sub: got res=%h z=%b c=%b v=%b want res=%h z=%b c=%b v=%b",
                                  result, zero, co, overflow, e.res, e.z, e.c, e.v); end
    endtask

    task automatic test_slt();
        int   lat, bn;
        exp_t e;
        issue(8'h80, 8'h01, 1'b0, 1'b1, 2'd3);
        wait_done(1'b0, lat, bn);
        e = sb.pop_front();
        total++;
        if ({result, zero, co, overflow} !== {e.res, e.z, e.c, e.v})
            begin bad++; $display("FAIL slt_ovf: got res=%h z=%b c=%b v=%b want res=%h z=%b c=%b v=%b",
                                  result, zero, co, overflow, e.res, e.z, e.c, e.v); end
        total++;
        if (overflow !== 1'b1) begin bad++; $display("FAIL slt_ovf_flag: got %b want 1", overflow); end
    endtask

    task automatic test_nor_or();
        int   lat, bn;
        exp_t e;
        issue(8'hF0, 8'h0F, 1'b1, 1'b1, 2'd0);
        wait_done(1'b0, lat, bn);
        e = sb.pop_front();
        total++;
        if ({result, zero, co, overflow} !== {e.res, e.z, e.c, e.v} || result !== 8'h00)
            begin bad++; $display("FAIL nor: got res=%h z=%b c=%b v=%b want res=%h z=%b c=%b v=%b",
                                  result, zero, co, overflow, e.res, e.z, e.c, e.v); end
        issue(8'hF0, 8'h0F, 1'b0, 1'b0, 2'd1);
        wait_done(1'b0, lat, bn);
        e = sb.pop_front();
        total++;
        if ({result, zero, co, overflow} !== {e.res, e.z, e.c, e.v} || result !== 8'hFF)
            begin bad++; $display("FAIL or: got res=%h z=%b c=%b v=%b want res=%h z=%b c=%b v=%b",
                                  result, zero, co, overflow, e.res, e.z, e.c, e.v); end
    endtask

    task automatic test_back_to_back();
        int   lat, bn, extra;
        exp_t e;
        issue(8'h3C, 8'h55, 1'b0, 1'b0, 2'd2);
        wait_done(1'b1, lat, bn);
        e = sb.pop_front();
        total++;
        if ({result, zero, co, overflow} !== {e.res, e.z, e.c, e.v})
            begin bad++; $display("FAIL ignored_start: got res=%h z=%b c=%b v=%b want res=%h z=%b c=%b v=%b",
                                  result, zero, co, overflow, e.res, e.z, e.c, e.v); end
        total++;
        if (lat !== W + 1) begin bad++; $display("FAIL poke_latency: got %0d want %0d", lat, W + 1); end
        // start during the done cycle must be accepted
        issue(8'hA5, 8'h5A, 1'b0, 1'b1, 2'd2);
        wait_done(1'b0, lat, bn);
        total++;
        if (lat !== W + 1 || bn !== W + 1)
            begin bad++; $display("FAIL b2b_timing: got lat=%0d busy=%0d want %0d/%0d", lat, bn, W + 1, W + 1); end
        e = sb.pop_front();
        total++;
        if ({result, zero, co, overflow} !== {e.res, e.z, e.c, e.v})
            begin bad++; $display("FAIL b2b: got res=%h z=%b c=%b v=%b want res=%h z=%b c=%b v=%b",
                                  result, zero, co, overflow, e.res, e.z, e.c, e.v); end
        extra = 0;
        for (int k = 0; k < W + 4; k++) begin
            @(posedge clk);
            #1;
            if (busy || done) extra++;
        end
        total++;
        if (extra !== 0) begin bad++; $display("FAIL idle_after_done: got %0d active cycles want 0", extra); end
    endtask

    task automatic test_random();
        int   lat, bn;
        exp_t e;
        for (int i = 0; i < 8; i++) begin
            issue(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 2'(i % 4));
            wait_done(1'b0, lat, bn);
            e = sb.pop_front();
            total++;
            if (lat !== W + 1 || {result, zero, co, overflow} !== {e.res, e.z, e.c, e.v})
                begin bad++; $display("FAIL rand%0d: got lat=%0d res=%h z=%b c=%b v=%b want lat=%0d res=%h z=%b c=%b v=%b",
                                      i, lat, result, zero, co, overflow, W + 1, e.res, e.z, e.c, e.v); end
        end
    endtask

    task automatic test_reset_mid();
        int   lat, bn, dn;
        exp_t e;
        issue(8'h33, 8'h44, 1'b1, 1'b0, 2'd1);
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        total++;
        if ({busy, done, result, zero, co, overflow} !== '0)
            begin bad++; $display("FAIL reset_mid: got busy=%b done=%b res=%h z=%b c=%b v=%b want all 0",
                                  busy, done, result, zero, co, overflow); end
        sb.delete();
        dn = 0;
        for (int k = 0; k < W + 4; k++) begin
            @(posedge clk);
            #1;
            if (k == 2) rst_n = 1'b1;
            if (done || busy) dn++;
        end
        total++;
        if (dn !== 0) begin bad++; $display("FAIL reset_no_done: got %0d active cycles want 0", dn); end
        issue(8'h7F, 8'h01, 1'b0, 1'b0, 2'd2);
        wait_done(1'b0, lat, bn);
        e = sb.pop_front();
        total++;
        if ({result, zero, co, overflow} !== {8'h80, 1'b0, 1'b0, 1'b1} || e.res !== 8'h80)
            begin bad++; $display("FAIL add_after_reset: got res=%h z=%b c=%b v=%b want res=80 z=0 c=0 v=1",
                                  result, zero, co, overflow); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_slt();
        test_nor_or();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
